// File: rtl/regfile_rat.sv
// Architectural register file with per-register pending-tag (rename) table.
// Optional REGFILE_COMMIT_BYPASS_EN forwards a same-cycle commit to reads.
module regfile_rat #(
    parameter int               DATA_W      = 32,
    parameter int               REG_NUM     = 32,
    parameter int               REG_W       = 5,
    parameter int               TAG_W       = 5,
    parameter logic [TAG_W-1:0] TAG_INVALID = 5'h1F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              alloc_en,
    input  logic [REG_W-1:0]  alloc_rd,
    input  logic [TAG_W-1:0]  alloc_tag,
    input  logic              rd_en,
    input  logic [REG_W-1:0]  rs1_addr,
    input  logic [REG_W-1:0]  rs2_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rs1_data,
    output logic [TAG_W-1:0]  rs1_tag,
    output logic [DATA_W-1:0] rs2_data,
    output logic [TAG_W-1:0]  rs2_tag,
    output logic [REG_W:0]    pend_cnt
);

    localparam int CNT_W = REG_W + 1;

    logic [DATA_W-1:0] regs_q [REG_NUM];
    logic [DATA_W-1:0] regs_d [REG_NUM];
    logic [TAG_W-1:0]  pend_q [REG_NUM];
    logic [TAG_W-1:0]  pend_d [REG_NUM];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              rd_valid_q;
    logic [DATA_W-1:0] rs1_data_q;
    logic [TAG_W-1:0]  rs1_tag_q;
    logic [DATA_W-1:0] rs2_data_q;
    logic [TAG_W-1:0]  rs2_tag_q;

    logic              commit_v;
    logic              clr;
    logic              alloc_v;
    logic              alloc_old_p;
    logic              alloc_new_p;
    logic              same_rd;
    logic              inc;
    logic              dec_a;
    logic              dec_c;

    logic [REG_W-1:0]  rs_a    [2];
    logic [DATA_W-1:0] op_data [2];
    logic [TAG_W-1:0]  op_tag  [2];

    assign commit_v    = (wb_tag != TAG_INVALID) && (wb_rd != '0);
    assign clr         = commit_v && (pend_q[wb_rd] == wb_tag);
    assign alloc_v     = alloc_en && (alloc_rd != '0);
    assign alloc_old_p = pend_q[alloc_rd] != TAG_INVALID;
    assign alloc_new_p = alloc_tag != TAG_INVALID;
    assign same_rd     = alloc_v && (alloc_rd == wb_rd);

    // Pending count tracks the actual set/clear transitions of the table
    assign inc   = alloc_v && !alloc_old_p && alloc_new_p;
    assign dec_a = alloc_v && alloc_old_p && !alloc_new_p;
    assign dec_c = clr && !same_rd;
    assign cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec_a) - CNT_W'(dec_c);

    assign rs_a[0] = rs1_addr;
    assign rs_a[1] = rs2_addr;

    // Next table state: commit writes value, alloc overrides the pending tag
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (commit_v) begin
            regs_d[wb_rd] = wb_data;
            if (clr) begin
                pend_d[wb_rd] = TAG_INVALID;
            end
        end
        if (alloc_v) begin
            pend_d[alloc_rd] = alloc_tag;
        end
    end

    // Operand lookup against the pre-edge table, x0 forced ready and zero
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            op_data[k] = regs_q[rs_a[k]];
            op_tag[k]  = pend_q[rs_a[k]];
            if (rs_a[k] == '0) begin
                op_data[k] = '0;
                op_tag[k]  = TAG_INVALID;
            end
`ifdef REGFILE_COMMIT_BYPASS_EN
            else if (commit_v && (wb_rd == rs_a[k]) &&
                     (wb_tag == pend_q[rs_a[k]])) begin
                op_data[k] = wb_data;
                op_tag[k]  = TAG_INVALID;
            end
`endif
        end
    end

    // Table, counter and registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
                pend_q[i] <= TAG_INVALID;
            end
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rs1_data_q <= '0;
            rs1_tag_q  <= TAG_INVALID;
            rs2_data_q <= '0;
            rs2_tag_q  <= TAG_INVALID;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rs1_data_q <= op_data[0];
                rs1_tag_q  <= op_tag[0];
                rs2_data_q <= op_data[1];
                rs2_tag_q  <= op_tag[1];
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rs1_data = rs1_data_q;
    assign rs1_tag  = rs1_tag_q;
    assign rs2_data = rs2_data_q;
    assign rs2_tag  = rs2_tag_q;
    assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_rat.sv
// Scoreboard bench for regfile_rat: expected read results are queued
// when the read is issued and compared when rd_valid returns.
module tb_regfile_rat;

    typedef logic [80:0] obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wb_tag;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        alloc_en;
    logic [4:0]  alloc_rd;
    logic [4:0]  alloc_tag;
    logic        rd_en;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rd_valid;
    logic [31:0] rs1_data;
    logic [4:0]  rs1_tag;
    logic [31:0] rs2_data;
    logic [4:0]  rs2_tag;
    logic [5:0]  pend_cnt;

    int   n_chk  = 0;
    int   n_fail = 0;
    obs_t exp_q[$];
    obs_t e;
    obs_t got;

    localparam logic [4:0] INV = 5'h1F;

    regfile_rat dut (
        .clk(clk), .rst(rst),
        .wb_tag(wb_tag), .wb_rd(wb_rd), .wb_data(wb_data),
        .alloc_en(alloc_en), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
        .rd_en(rd_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_valid(rd_valid),
        .rs1_data(rs1_data), .rs1_tag(rs1_tag),
        .rs2_data(rs2_data), .rs2_tag(rs2_tag),
        .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic obs_t mk(input logic [31:0] d1, input logic [4:0] t1,
                                input logic [31:0] d2, input logic [4:0] t2,
                                input logic [5:0] c);
        return {1'b1, d1, t1, d2, t2, c};
    endfunction

    function automatic obs_t snap();
        return {rd_valid, rs1_data, rs1_tag, rs2_data, rs2_tag, pend_cnt};
    endfunction

    // drive one full cycle of inputs, then step past the edge
    task automatic cyc(input logic ae, input logic [4:0] ard,
                       input logic [4:0] atg, input logic [4:0] wt,
                       input logic [4:0] wr, input logic [31:0] wd,
                       input logic re, input logic [4:0] r1,
                       input logic [4:0] r2);
        alloc_en = ae; alloc_rd = ard; alloc_tag = atg;
        wb_tag = wt; wb_rd = wr; wb_data = wd;
        rd_en = re; rs1_addr = r1; rs2_addr = r2;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(0, 0, 0, INV, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, INV, 0, 0, 0, 0, 0);
        rst = 1'b0;
        got = snap(); n_chk++;
        if (got !== {1'b0, 32'h0, INV, 32'h0, INV, 6'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h required %h", got,
                     {1'b0, 32'h0, INV, 32'h0, INV, 6'd0});
        end
        exp_q.push_back(mk(0, INV, 0, INV, 0));
        cyc(0, 0, 0, INV, 0, 0, 1, 3, 0);
        e = exp_q.pop_front(); got = snap(); n_chk++;
        if (got !== e) begin
            n_fail++; $display("FAIL reset_read: got %h required %h", got, e);
        end
        cyc(0, 0, 0, INV, 0, 0, 0, 0, 0);
        got = snap(); n_chk++;
        if (got !== {1'b0, 32'h0, INV, 32'h0, INV, 6'd0}) begin
            n_fail++;
            $display("FAIL idle_hold: got %h required %h", got,
                     {1'b0, 32'h0, INV, 32'h0, INV, 6'd0});
        end
    endtask

    task automatic test_commit();
        cyc(1, 5, 2, INV, 0, 0, 0, 0, 0);
        n_chk++;
        if (pend_cnt !== 6'd1) begin
            n_fail++; $display("FAIL alloc_cnt: got %0d required 1", pend_cnt);
        end
        exp_q.push_back(mk(0, 5'd2, 0, INV, 1));
        cyc(0, 0, 0, INV, 0, 0, 1, 5, 0);
        e = exp_q.pop_front(); got = snap(); n_chk++;
        if (got !== e) begin
            n_fail++; $display("FAIL pend_read: got %h required %h", got, e);
        end
        cyc(0, 0, 0, 5'd2, 5, 32'hDEAD, 0, 0, 0);
        n_chk++;
        if (pend_cnt !== 6'd0) begin
            n_fail++; $display("FAIL commit_cnt: got %0d required 0", pend_cnt);
        end
        exp_q.push_back(mk(32'hDEAD, INV, 0, INV, 0));
        cyc(0, 0, 0, INV, 0, 0, 1, 5, 0);
        e = exp_q.pop_front(); got = snap(); n_chk++;
        if (got !== e) begin
            n_fail++; $display("FAIL commit_read: got %h required %h", got, e);
        end
    endtask

    task automatic test_younger();
        cyc(1, 7, 5'd1, INV, 0, 0, 0, 0, 0);
        cyc(1, 7, 5'd4, INV, 0, 0, 0, 0, 0);
        n_chk++;
        if (pend_cnt !== 6'd1) begin
            n_fail++; $display("FAIL realloc_cnt: got %0d required 1", pend_cnt);
        end
        cyc(0, 0, 0, 5'd1, 7, 32'h11, 0, 0, 0);
        n_chk++;
        if (pend_cnt !== 6'd1) begin
            n_fail++; $display("FAIL stale_cnt: got %0d required 1", pend_cnt);
        end
        exp_q.push_back(mk(32'h11, 5'd4, 32'hDEAD, INV, 1));
        cyc(0, 0, 0, INV, 0, 0, 1, 7, 5);
        e = exp_q.pop_front(); got = snap(); n_chk++;
        if (got !== e) begin
            n_fail++; $display("FAIL stale_read: got %h required %h", got, e);
        end
        cyc(0, 0, 0, 5'd4, 7, 32'h22, 0, 0, 0);
        exp_q.push_back(mk(32'h22, INV, 32'h22, INV, 0));
        cyc(0, 0, 0, INV, 0, 0, 1, 7, 7);
        e = exp_q.pop_front(); got = snap(); n_chk++;
        if (got !== e) begin
            n_fail++; $display("FAIL young_read: got %h required %h", got, e);
        end
    endtask

    task automatic test_same_cycle();
        exp_q.push_back(mk(0, INV, 0, INV, 1));
        cyc(1, 9, 5'd3, INV, 0, 0, 1, 9, 0);
        e = exp_q.pop_front(); got = snap(); n_chk++;
        if (got !== e) begin
            n_fail++; $display("FAIL alloc_read_old: got %h required %h", got, e);
        end
        exp_q.push_back(mk(0, 5'd3, 0, INV, 1));
        cyc(0, 0, 0, INV, 0, 0, 1, 9, 0);
        e = exp_q.pop_front(); got = snap(); n_chk++;
        if (got !== e) begin
            n_fail++; $display("FAIL alloc_read_new: got %h required %h", got, e);
        end
    endtask

    task automatic test_bypass();
        cyc(1, 6, 5'd8, INV, 0, 0, 0, 0, 0);
`ifdef REGFILE_COMMIT_BYPASS_EN
        exp_q.push_back(mk(32'h55, INV, 0, 5'd3, 1));
`else
        exp_q.push_back(mk(0, 5'd8, 0, 5'd3, 1));
`endif
        cyc(0, 0, 0, 5'd8, 6, 32'h55, 1, 6, 9);
        e = exp_q.pop_front(); got = snap(); n_chk++;
        if (got !== e) begin
            n_fail++; $display("FAIL bypass_read: got %h required %h", got, e);
        end
        cyc(1, 6, 5'd10, INV, 0, 0, 0, 0, 0);
`ifdef REGFILE_COMMIT_BYPASS_EN
        exp_q.push_back(mk(32'h66, INV, 0, INV, 2));
`else
        exp_q.push_back(mk(32'h55, 5'd10, 0, INV, 2));
`endif
        cyc(1, 6, 5'd12, 5'd10, 6, 32'h66, 1, 6, 0);
        e = exp_q.pop_front(); got = snap(); n_chk++;
        if (got !== e) begin
            n_fail++; $display("FAIL bypass_alloc: got %h required %h", got, e);
        end
        exp_q.push_back(mk(32'h66, 5'd12, 0, 5'd3, 2));
        cyc(0, 0, 0, INV, 0, 0, 1, 6, 9);
        e = exp_q.pop_front(); got = snap(); n_chk++;
        if (got !== e) begin
            n_fail++; $display("FAIL same_rd_read: got %h required %h", got, e);
        end
        cyc(1, 10, 5'd5, 5'd3, 9, 32'h99, 0, 0, 0);
        n_chk++;
        if (pend_cnt !== 6'd2) begin
            n_fail++; $display("FAIL net_zero_cnt: got %0d required 2", pend_cnt);
        end
    endtask

    task automatic test_x0_and_reset();
        cyc(1, 0, 5'd7, 5'd7, 0, 32'hFFFF, 0, 0, 0);
        exp_q.push_back(mk(0, INV, 0, INV, 2));
        cyc(0, 0, 0, INV, 0, 0, 1, 0, 0);
        e = exp_q.pop_front(); got = snap(); n_chk++;
        if (got !== e) begin
            n_fail++; $display("FAIL x0_read: got %h required %h", got, e);
        end
        rst = 1'b1;
        cyc(1, 11, 5'd9, INV, 0, 0, 1, 6, 10);
        rst = 1'b0;
        got = snap(); n_chk++;
        if (got !== {1'b0, 32'h0, INV, 32'h0, INV, 6'd0}) begin
            n_fail++;
            $display("FAIL mid_reset: got %h required %h", got,
                     {1'b0, 32'h0, INV, 32'h0, INV, 6'd0});
        end
        exp_q.push_back(mk(0, INV, 0, INV, 0));
        cyc(0, 0, 0, INV, 0, 0, 1, 10, 6);
        e = exp_q.pop_front(); got = snap(); n_chk++;
        if (got !== e) begin
            n_fail++; $display("FAIL post_reset_read: got %h required %h", got, e);
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d left required 0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_commit();
        test_younger();
        test_same_cycle();
        test_bypass();
        test_x0_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
